radar_sweep_ctrl: RTL and testbench



---
 rtl/radar_pkg.sv | 25 ++
 rtl/radar_timer.sv | 35 +++
 rtl/radar_sweep_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_radar_sweep_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/radar_pkg.sv
// Shared types and constants for the radar sweep controller.
package radar_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StTrig,
    StWait,
    StNext,
    StDone
  } state_e;

  localparam logic [1:0] POS_LEFT   = 2'b00;
  localparam logic [1:0] POS_CENTRE = 2'b01;
  localparam logic [1:0] POS_RIGHT  = 2'b10;

  // Wide enough for any practical ranger; users slice to their distance width.
  localparam int unsigned DistMaxW = 64;
  localparam logic [DistMaxW-1:0] DIST_TIMEOUT = '1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/radar_timer.sv
// Phase timer: up-counter with synchronous clear and a terminal-count compare against a
// selectable limit. Saturates at the limit so tc stays asserted until cleared.
module radar_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] limit,
  output logic             tc
);

  logic [Width-1:0] count_q, count_d;

  assign tc = (count_q == limit);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/radar_sweep_ctrl.sv
// Radar sweep sequencer: steps the servo left/centre/right, triggers one range measurement per
// position and latches each result. Define RADAR_CONTINUOUS_EN to repeat sweeps until abort.
module radar_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned DIST_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [1:0]        ctr,
  output logic              trig_req,
  input  logic              meas_done,
  input  logic [DIST_W-1:0] dist_in,
  output logic [DIST_W-1:0] dist_l,
  output logic [DIST_W-1:0] dist_c,
  output logic [DIST_W-1:0] dist_r,
  output logic [2:0]        valid,
  output logic [2:0]        tout,
  output logic              busy,
  output logic              done
);

  import radar_pkg::*;

  localparam int unsigned TimerW = $clog2(max_u(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [TimerW-1:0] SettleLim  = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLim = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [DIST_W-1:0] DistTimeout = DIST_TIMEOUT[DIST_W-1:0];

`ifdef RADAR_CONTINUOUS_EN
  localparam bit Continuous = 1'b1;
`else
  localparam bit Continuous = 1'b0;
`endif

  state_e state_q, state_d;

  logic [1:0]        pos_q, pos_d;
  logic [2:0]        valid_q, valid_d;
  logic [2:0]        tout_q, tout_d;
  logic [DIST_W-1:0] dist_l_q, dist_l_d;
  logic [DIST_W-1:0] dist_c_q, dist_c_d;
  logic [DIST_W-1:0] dist_r_q, dist_r_d;

  logic              abort_act;
  logic [2:0]        pos_oh;
  logic              cap_en;
  logic [DIST_W-1:0] cap_val;

  logic              timer_clr;
  logic              timer_en;
  logic [TimerW-1:0] timer_limit;
  logic              timer_tc;

  // abort is meaningless in IDLE, so it only takes effect once a sweep is running.
  assign abort_act = abort && (state_q != StIdle);
  assign pos_oh    = 3'b001 << pos_q;

  // Every state entry restarts the phase timer.
  assign timer_clr   = (state_d != state_q);
  assign timer_en    = (state_q == StSettle) || (state_q == StWait);
  assign timer_limit = (state_q == StSettle) ? SettleLim : TimeoutLim;

  radar_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .en   (timer_en),
    .limit(timer_limit),
    .tc   (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_act) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (start) state_d = StSettle;
        StSettle: if (timer_tc) state_d = StTrig;
        StTrig:   state_d = StWait;
        StWait:   if (meas_done || timer_tc) state_d = StNext;
        StNext:   state_d = (pos_q == POS_RIGHT) ? StDone : StSettle;
        StDone:   state_d = Continuous ? StSettle : StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ctr      = POS_CENTRE;
    trig_req = 1'b0;
    done     = 1'b0;
    busy     = (state_q != StIdle);
    case (state_q)
      StSettle, StWait, StNext: ctr = pos_q;
      StTrig: begin
        ctr      = pos_q;
        trig_req = !abort_act;
      end
      StDone:  done = !abort_act;
      default: ;
    endcase
  end

  always_comb begin
    pos_d    = pos_q;
    valid_d  = valid_q;
    tout_d   = tout_q;
    dist_l_d = dist_l_q;
    dist_c_d = dist_c_q;
    dist_r_d = dist_r_q;
    cap_en   = 1'b0;
    cap_val  = dist_in;
    if (!abort_act) begin
      case (state_q)
        StIdle: begin
          if (start) begin
            pos_d   = POS_LEFT;
            valid_d = '0;
            tout_d  = '0;
          end
        end
        StWait: begin
          // A measurement landing on the timeout cycle still counts as a measurement.
          if (meas_done) begin
            cap_en  = 1'b1;
            valid_d = valid_q | pos_oh;
          end else if (timer_tc) begin
            cap_en  = 1'b1;
            cap_val = DistTimeout;
            tout_d  = tout_q | pos_oh;
          end
        end
        StNext: begin
          if (pos_q != POS_RIGHT) pos_d = pos_q + 2'd1;
        end
        StDone: begin
          if (Continuous) begin
            pos_d   = POS_LEFT;
            valid_d = '0;
            tout_d  = '0;
          end
        end
        default: ;
      endcase
    end
    if (cap_en) begin
      if (pos_oh[0]) dist_l_d = cap_val;
      if (pos_oh[1]) dist_c_d = cap_val;
      if (pos_oh[2]) dist_r_d = cap_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= POS_LEFT;
      valid_q  <= '0;
      tout_q   <= '0;
      dist_l_q <= '0;
      dist_c_q <= '0;
      dist_r_q <= '0;
    end else begin
      pos_q    <= pos_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      dist_l_q <= dist_l_d;
      dist_c_q <= dist_c_d;
      dist_r_q <= dist_r_d;
    end
  end

  assign dist_l = dist_l_q;
  assign dist_c = dist_c_q;
  assign dist_r = dist_r_q;
  assign valid  = valid_q;
  assign tout   = tout_q;

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Self-checking bench for radar_sweep_ctrl: directed vector table, randomized sweeps against a
// cycle-timing model, reset/abort sequences, and the RADAR_CONTINUOUS_EN repeat mode.
module tb_radar_sweep_ctrl;

  localparam int S  = 10;
  localparam int T  = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          meas_done = 1'b0;
  logic [DW-1:0] dist_in = '0;
  logic [1:0]    ctr;
  logic          trig_req, busy, done;
  logic [DW-1:0] dist_l, dist_c, dist_r;
  logic [2:0]    valid, tout;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_dist [3];

  typedef struct packed {
    int            k0, k1, k2;
    logic [DW-1:0] v0, v1, v2;
    int            abort_pos;
    logic [2:0]    ev, et;
  } vec_t;

  vec_t vecs [4];

  radar_sweep_ctrl #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T),
    .DIST_W        (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .ctr      (ctr),
    .trig_req (trig_req),
    .meas_done(meas_done),
    .dist_in  (dist_in),
    .dist_l   (dist_l),
    .dist_c   (dist_c),
    .dist_r   (dist_r),
    .valid    (valid),
    .tout     (tout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input int k);
    return (k >= 1) && (k <= T);
  endfunction

  // k = cycles from trig_req to meas_done (0 = ranger never answers; > T = answer too late).
  task automatic sweep(input int k0, input int k1, input int k2,
                       input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                       input int abort_pos, input logic [2:0] ev, input logic [2:0] et);
    int k[3];
    logic [DW-1:0] v[3];
    int w[3];
    int tt[3];
    int done_at, abort_at, end_at, res_at, md_at, md_pos, p;
    logic [1:0] ec;
    logic eb, etr, ed;
    k[0] = k0; k[1] = k1; k[2] = k2;
    v[0] = v0; v[1] = v1; v[2] = v2;
    for (int i = 0; i < 3; i++) w[i] = in_range(k[i]) ? k[i] : T;
    tt[0] = S + 1;
    for (int i = 1; i < 3; i++) tt[i] = tt[i-1] + w[i-1] + S + 2;
    done_at  = tt[2] + w[2] + 2;
    abort_at = (abort_pos >= 0) ? tt[abort_pos] - S + 4 : -1;
    end_at   = (abort_at >= 0) ? abort_at + 1 : done_at + 1;
    res_at   = (abort_at >= 0) ? abort_at + 1 : done_at;
    for (int i = 0; i < 3; i++) begin
      if (abort_at < 0 || i < abort_pos) exp_dist[i] = in_range(k[i]) ? v[i] : '1;
    end
    md_at = -1; md_pos = 0; p = 0;
    for (int c = 0; c <= end_at; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == 3);
      abort = (c == abort_at);
`ifdef RADAR_CONTINUOUS_EN
      if (abort_at < 0 && c == done_at + 1) abort = 1'b1;
`endif
      meas_done = (c == md_at);
      dist_in   = meas_done ? v[md_pos] : DW'($urandom);
      #1;
      ec = 2'b01; etr = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (c >= tt[i] - S && c <= tt[i] + w[i] + 1) ec = 2'(i);
        if (c == tt[i]) etr = 1'b1;
      end
      eb = (c >= 1) && (c <= done_at);
      ed = (c == done_at);
      if (abort_at >= 0 && c > abort_at) begin
        ec = 2'b01;
        eb = 1'b0;
      end
`ifdef RADAR_CONTINUOUS_EN
      if (abort_at < 0 && c == done_at + 1) begin
        ec = 2'b00;
        eb = 1'b1;
      end
`endif
      chk("ctr", ctr, ec);
      chk("busy", busy, eb);
      chk("trig_req", trig_req, etr);
      chk("done", done, ed);
      if (c == res_at) begin
        chk("dist_l", dist_l, exp_dist[0]);
        chk("dist_c", dist_c, exp_dist[1]);
        chk("dist_r", dist_r, exp_dist[2]);
        chk("valid", valid, ev);
        chk("tout", tout, et);
      end
      if (trig_req && p < 3) begin
        if (k[p] > 0) begin
          md_at  = c + k[p];
          md_pos = p;
        end
        p++;
      end
    end
    // A stray measurement while idle must not disturb the stored results.
    @(negedge clk);
    start = 1'b0; abort = 1'b0; meas_done = 1'b1; dist_in = 16'h5A5A;
    @(negedge clk);
    meas_done = 1'b0;
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_ctr", ctr, 2'b01);
    chk("idle_dist_l", dist_l, exp_dist[0]);
    chk("idle_dist_c", dist_c, exp_dist[1]);
    chk("idle_dist_r", dist_r, exp_dist[2]);
`ifdef RADAR_CONTINUOUS_EN
    if (abort_at >= 0) chk("idle_valid", valid, ev);
    else chk("idle_valid", valid, 3'b000);
`else
    chk("idle_valid", valid, ev);
`endif
  endtask

  task automatic mid_reset();
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      start     = (c == 0);
      meas_done = (c == 16);
      dist_in   = 16'd77;
      #1;
      if (c == 20) chk("pre_reset_valid", valid, 3'b001);
    end
    @(negedge clk);
    meas_done = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_ctr", ctr, 2'b01);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 3'b000);
    chk("rst_dist_l", dist_l, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_dist[i] = '0;
  endtask

`ifdef RADAR_CONTINUOUS_EN
  task automatic cont_two_sweeps();
    int len;
    int ndone;
    len   = 3 * S + 3 * T + 7;
    ndone = 0;
    for (int c = 0; c <= 2 * len; c++) begin
      @(negedge clk);
      start = (c == 0);
      meas_done = 1'b0;
      #1;
      if (done) ndone++;
      if (c >= 1) chk("cont_busy", busy, 1'b1);
      if (c == len + 1) chk("cont_ctr_restart", ctr, 2'b00);
    end
    chk("cont_done_count", ndone, 2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("cont_abort_busy", busy, 1'b0);
  endtask
`endif

  initial begin
    int ka, kb, kc;
    logic [2:0] mv;
    for (int i = 0; i < 3; i++) exp_dist[i] = '0;
    vecs[0] = '{5, 5, 5, 16'd100, 16'd200, 16'd300, -1, 3'b111, 3'b000};
    vecs[1] = '{5, 0, 5, 16'd1, 16'd2, 16'd3, -1, 3'b101, 3'b010};
    vecs[2] = '{3, T, 7, 16'd7, 16'd42, 16'd9, -1, 3'b111, 3'b000};
    vecs[3] = '{5, 5, 5, 16'd11, 16'd22, 16'd33, 2, 3'b011, 3'b000};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctr", ctr, 2'b01);
    chk("reset_busy", busy, 1'b0);
    chk("reset_trig", trig_req, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_valid", valid, 3'b000);
    chk("reset_tout", tout, 3'b000);
    chk("reset_dist", {dist_l, dist_c}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mid_reset();

    for (int i = 0; i < 4; i++) begin
      sweep(vecs[i].k0, vecs[i].k1, vecs[i].k2, vecs[i].v0, vecs[i].v1, vecs[i].v2,
            vecs[i].abort_pos, vecs[i].ev, vecs[i].et);
    end

    for (int r = 0; r < 8; r++) begin
      ka = int'($urandom_range(0, T + 3));
      kb = int'($urandom_range(0, T + 3));
      kc = int'($urandom_range(0, T + 3));
      mv = {in_range(kc), in_range(kb), in_range(ka)};
      sweep(ka, kb, kc, DW'($urandom), DW'($urandom), DW'($urandom), -1, mv, ~mv);
    end

`ifdef RADAR_CONTINUOUS_EN
    cont_two_sweeps();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
